// File: rtl/cpu_trace_emitter_pkg.sv
// cpu_trace_emitter_pkg: FSM states, ASCII constants and helpers for the trace emitter.
// The NL state exists only when CPU_TRACE_EMITTER_NEWLINE_EN is defined.
package cpu_trace_emitter_pkg;

    typedef enum logic [3:0] {
        IDLE, START, TIME, AT, PC, COLON, SP1, KIND, OPND, SP2, LT, EQ, SP3, DATA, END
`ifdef CPU_TRACE_EMITTER_NEWLINE_EN
        , NL
`endif
    } state_t;

    localparam logic [7:0] CH_NUL    = 8'h00;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_NL     = 8'h0A;
    localparam logic [7:0] CH_ZERO   = 8'h30;

    localparam logic [15:0] TIME_MAX = 16'd9999;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? CH_ZERO + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

endpackage

// File: rtl/cpu_trace_bin2dec.sv
// cpu_trace_bin2dec: BCD digits and significant-digit counts for the clamped time and register number.
module cpu_trace_bin2dec (
    input  logic [13:0]      t,
    input  logic [4:0]       r,
    output logic [3:0][3:0]  t_dig,
    output logic [2:0]       t_cnt,
    output logic [1:0][3:0]  r_dig,
    output logic [2:0]       r_cnt
);

    always_comb begin
        t_dig[3] = 4'(t / 14'd1000);
        t_dig[2] = 4'((t / 14'd100) % 14'd10);
        t_dig[1] = 4'((t / 14'd10) % 14'd10);
        t_dig[0] = 4'(t % 14'd10);
        t_cnt    = (t >= 14'd1000) ? 3'd4 : (t >= 14'd100) ? 3'd3 : (t >= 14'd10) ? 3'd2 : 3'd1;
        r_dig[1] = 4'(r / 5'd10);
        r_dig[0] = 4'(r % 5'd10);
        r_cnt    = (r >= 5'd10) ? 3'd2 : 3'd1;
    end

endmodule

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter: serialises register/memory write records into an ASCII character stream.
// Define CPU_TRACE_EMITTER_NEWLINE_EN to terminate each record with a newline.
module cpu_trace_emitter
    import cpu_trace_emitter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rec_kind,
    input  logic [15:0] rec_time,
    input  logic [31:0] rec_pc,
    input  logic [4:0]  rec_reg,
    input  logic [31:0] rec_addr,
    input  logic [31:0] rec_data,
    output logic [7:0]  char,
    output logic        char_valid
);

    state_t state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        kind_q;
    logic [13:0] t_q;
    logic [4:0]  r_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [7:0]  ch;
    logic [3:0][3:0] t_dig;
    logic [1:0][3:0] r_dig;
    logic [2:0]  t_cnt, r_cnt;
    logic        accept, last_state;

    cpu_trace_bin2dec u_bin2dec (
        .t     (t_q),
        .r     (r_q),
        .t_dig (t_dig),
        .t_cnt (t_cnt),
        .r_dig (r_dig),
        .r_cnt (r_cnt)
    );

`ifdef CPU_TRACE_EMITTER_NEWLINE_EN
    assign last_state = (state == NL);
`else
    assign last_state = (state == END);
`endif

    // reset gates the outputs directly so they drop without waiting for an edge
    assign in_ready   = !reset && (state == IDLE || last_state);
    assign accept     = in_valid && in_ready;
    assign char_valid = !reset && (state != IDLE);
    assign char       = char_valid ? ch : CH_NUL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            kind_q <= 1'b0;
            t_q    <= 14'd0;
            r_q    <= 5'd0;
            pc_q   <= 32'd0;
            addr_q <= 32'd0;
            data_q <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                kind_q <= rec_kind;
                t_q    <= (rec_time > TIME_MAX) ? TIME_MAX[13:0] : rec_time[13:0];
                r_q    <= rec_reg;
                pc_q   <= rec_pc;
                addr_q <= rec_addr;
                data_q <= rec_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ch      = CH_NUL;
        case (state)
            IDLE:  state_n = accept ? START : IDLE;
            START: begin
                ch      = CH_CARET;
                state_n = TIME;
                cnt_n   = t_cnt - 3'd1;
            end
            TIME: begin
                ch      = CH_ZERO + {4'h0, t_dig[cnt[1:0]]};
                state_n = (cnt == 3'd0) ? AT : TIME;
                cnt_n   = cnt - 3'd1;
            end
            AT: begin
                ch      = CH_AT;
                state_n = PC;
                cnt_n   = 3'd7;
            end
            PC: begin
                ch      = hex_char(pc_q[{cnt, 2'b00} +: 4]);
                state_n = (cnt == 3'd0) ? COLON : PC;
                cnt_n   = cnt - 3'd1;
            end
            COLON: begin
                ch      = CH_COLON;
                state_n = SP1;
            end
            SP1: begin
                ch      = CH_SP;
                state_n = KIND;
            end
            KIND: begin
                ch      = kind_q ? CH_STAR : CH_DOLLAR;
                state_n = OPND;
                cnt_n   = kind_q ? 3'd7 : r_cnt - 3'd1;
            end
            OPND: begin
                ch      = kind_q ? hex_char(addr_q[{cnt, 2'b00} +: 4]) : CH_ZERO + {4'h0, r_dig[cnt[0]]};
                state_n = (cnt == 3'd0) ? SP2 : OPND;
                cnt_n   = cnt - 3'd1;
            end
            SP2: begin
                ch      = CH_SP;
                state_n = LT;
            end
            LT: begin
                ch      = CH_LT;
                state_n = EQ;
            end
            EQ: begin
                ch      = CH_EQ;
                state_n = SP3;
            end
            SP3: begin
                ch      = CH_SP;
                state_n = DATA;
                cnt_n   = 3'd7;
            end
            DATA: begin
                ch      = hex_char(data_q[{cnt, 2'b00} +: 4]);
                state_n = (cnt == 3'd0) ? END : DATA;
                cnt_n   = cnt - 3'd1;
            end
            END: begin
                ch = CH_HASH;
`ifdef CPU_TRACE_EMITTER_NEWLINE_EN
                state_n = NL;
`else
                state_n = accept ? START : IDLE;
`endif
            end
`ifdef CPU_TRACE_EMITTER_NEWLINE_EN
            NL: begin
                ch      = CH_NL;
                state_n = accept ? START : IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule
